// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of a word-wide data memory.
// Handles one byte, halfword or word request at a time. The stage checks
// alignment and range, performs read-modify-write for sub-word stores, and
// returns sign- or zero-extended load data.
// Optional feature: define LSU_PERF_CNT_EN to add the completed-load and
// completed-store counters perf_ld_cnt_o / perf_st_cnt_o.
module lsu_ctrl #(
  parameter int DMEM_AW = 11,
  parameter int XLEN    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [XLEN-1:0]    req_addr_i,
  input  logic [XLEN-1:0]    req_wdata_i,
  output logic               rsp_valid_o,
  output logic               rsp_err_o,
  output logic [XLEN-1:0]    rsp_rdata_o,
  output logic               dmem_st_en_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [31:0]        dmem_st_data_o,
  input  logic [31:0]        dmem_ld_data_i
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_ld_cnt_o,
  output logic [31:0]        perf_st_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSV = 2'b11} size_t;

  state_t      state_q;
  logic        we_q;
  size_t       size_q;
  logic        uns_q;
  logic [1:0]  addr_lo_q;   // byte offset within the word; the word address lives in dmem_addr_o
  logic [31:0] wdata_q;
  logic [31:0] old_q;       // word read in RD, base for the sub-word merge

  logic             req_err;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [XLEN-1:0]  ld_ext;
  logic [31:0]      st_merge;

  // Flag requests that are out of range, misaligned or of reserved size.
  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_err = |req_addr_i[XLEN-1:DMEM_AW];
    case (size_t'(req_size_i))
      SZ_HALF: req_err = req_err | req_addr_i[0];
      SZ_WORD: req_err = req_err | (|req_addr_i[1:0]);
      SZ_RSV:  req_err = 1'b1;
      default: ;
    endcase
  end

  // Pick the addressed lane(s) out of the memory word and extend them.
  always_comb begin
    lane_b = dmem_ld_data_i[{addr_lo_q, 3'b000} +: 8];
    lane_h = dmem_ld_data_i[{addr_lo_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: ld_ext = {{(XLEN-8){~uns_q & lane_b[7]}}, lane_b};
      SZ_HALF: ld_ext = {{(XLEN-16){~uns_q & lane_h[15]}}, lane_h};
      default: ld_ext = XLEN'(dmem_ld_data_i);
    endcase
  end

  // Build the store word: full wdata for word stores, old word with lanes replaced otherwise.
  always_comb begin
    st_merge = old_q;
    case (size_q)
      SZ_BYTE: st_merge[{addr_lo_q, 3'b000} +: 8]     = wdata_q[7:0];
      SZ_HALF: st_merge[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_merge = wdata_q;
    endcase
  end

  // Combinational handshake and memory write strobe, at rest outside their states.
  always_comb begin
    req_ready_o    = (state_q == S_IDLE);
    dmem_st_en_o   = (state_q == S_WR) & rst_ni;   // a reset in WR suppresses the write
    dmem_st_data_o = (state_q == S_WR) ? st_merge : 32'h0;
  end

  // Request FSM with registered response and memory address.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'h0;
      old_q       <= 32'h0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      dmem_addr_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            size_q      <= size_t'(req_size_i);
            uns_q       <= req_unsigned_i;
            addr_lo_q   <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[31:0];
            dmem_addr_o <= {req_addr_i[DMEM_AW-1:2], 2'b00};
            if (req_err) begin
              state_q     <= S_RSP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else if (!req_we_i || size_t'(req_size_i) != SZ_WORD) begin
              state_q <= S_RD;
            end else begin
              state_q <= S_WR;
            end
          end
        end
        S_RD: begin
          old_q <= dmem_ld_data_i;
          if (we_q) begin
            state_q <= S_WR;
          end else begin
            state_q     <= S_RSP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= ld_ext;
          end
        end
        S_WR: begin
          state_q     <= S_RSP;
          rsp_valid_o <= 1'b1;
        end
        default: state_q <= S_IDLE;   // S_RSP
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Count error-free completions in the response cycle; counters wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_ld_cnt_o <= 32'h0;
      perf_st_cnt_o <= 32'h0;
    end else if (state_q == S_RSP && !rsp_err_o) begin
      if (we_q) perf_st_cnt_o <= perf_st_cnt_o + 32'd1;
      else      perf_ld_cnt_o <= perf_ld_cnt_o + 32'd1;
    end
  end
`endif

endmodule
